uart_alu_intf: RTL and testbench

//  Sits downstream of the UART receiver and upstream of the UART transmitter.
//  - Consumes received bytes in order: operand A, then operand B, then opcode.
//  - Presents them to a combinational ALU and captures the ALU result.
//  - Hands the result to the transmitter with a one-cycle start pulse, then

---
 rtl/uart_alu_intf.sv | 155 +++++++++++++++
 tb/tb_uart_alu_intf.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_intf.sv
// Byte sequencer between UART RX, a combinational ALU and UART TX: collects A, B, opcode,
// captures the ALU result and launches one TX frame. Optional inter-byte timeout: INTF_TIMEOUT_EN.
module uart_alu_intf #(
    parameter int D_BIT          = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx_done_tick,
    input  logic [D_BIT-1:0]   i_rx_data,
    input  logic [D_BIT-1:0]   i_alu_result,
    input  logic               i_tx_done_tick,
    output logic [D_BIT-1:0]   o_data_a,
    output logic [D_BIT-1:0]   o_data_b,
    output logic [OP_BITS-1:0] o_op,
    output logic               o_tx_start,
    output logic [D_BIT-1:0]   o_tx_data,
    output logic               o_busy,
    output logic               o_drop_tick,
    output logic               o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX
    } state_t;

    state_t             state_q, state_d;
    logic [D_BIT-1:0]   data_a_q, data_a_d;
    logic [D_BIT-1:0]   data_b_q, data_b_d;
    logic [OP_BITS-1:0] op_q, op_d;
    logic [D_BIT-1:0]   tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               drop_q, drop_d;
    logic               busy;
    logic               collecting;
    logic               timeout_hit;

    assign busy       = (state_q == CALC) || (state_q == SEND) || (state_q == WAIT_TX);
    assign collecting = (state_q == WAIT_B) || (state_q == WAIT_OP);

`ifdef INTF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    // A byte landing on the terminal count wins over the timeout.
    assign timeout_hit = collecting && !i_rx_done_tick && (cnt_q == CNT_MAX);

    // Counter only advances while lingering in a collect state; any byte,
    // state change or timeout brings it back to zero.
    always_comb begin
        cnt_d = '0;
        if (collecting && !i_rx_done_tick && !timeout_hit)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_hit;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
    assign unused_cfg  = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        drop_d     = i_rx_done_tick && busy;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done_tick) begin
                    data_a_d = i_rx_data;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done_tick) begin
                    data_b_d = i_rx_data;
                    state_d  = WAIT_OP;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done_tick) begin
                    op_d    = i_rx_data[OP_BITS-1:0];
                    state_d = CALC;
                end else if (timeout_hit) begin
                    state_d = WAIT_A;
                end
            end
            CALC: begin
                // Operands have been stable for a full cycle by now.
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done_tick)
                    state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            data_a_q   <= '0;
            data_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            drop_q     <= drop_d;
        end
    end

    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    assign o_op        = op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_drop_tick = drop_q;
    assign o_busy      = busy;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed + randomized bench for uart_alu_intf; the ALU is a small behavioural model
// and expected results come from the bytes the bench itself sends.
module tb_uart_alu_intf;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_rx_done_tick = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic [7:0] i_alu_result;
    logic       i_tx_done_tick = 1'b0;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_op;
    logic       o_tx_start, o_busy, o_drop_tick, o_timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int tx_start_cnt = 0;
    int drop_cnt     = 0;
    int timeout_cnt  = 0;

    uart_alu_intf #(.D_BIT(8), .OP_BITS(6), .TIMEOUT_CYCLES(16)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
        .i_alu_result(i_alu_result), .i_tx_done_tick(i_tx_done_tick),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
        .o_drop_tick(o_drop_tick), .o_timeout(o_timeout)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign i_alu_result = alu_f(o_data_a, o_data_b, o_op);

    always @(negedge i_clock) begin
        if (o_tx_start)  tx_start_cnt++;
        if (o_drop_tick) drop_cnt++;
        if (o_timeout)   timeout_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        step();
        i_rx_done_tick = 1'b0;
    endtask

    task automatic finish_tx();
        i_tx_done_tick = 1'b1;
        step();
        i_tx_done_tick = 1'b0;
        chk("busy_after_txdone", 32'(o_busy), 0);
    endtask

    // Sends a full A/B/opcode sequence and checks capture, start latency and result.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        int s0;
        s0 = tx_start_cnt;
        send_byte(a);
        chk("data_a", 32'(o_data_a), 32'(a));
        chk("no_start_a", 32'(o_tx_start), 0);
        send_byte(b);
        chk("data_b", 32'(o_data_b), 32'(b));
        chk("no_start_b", 32'(o_tx_start), 0);
        send_byte(opb);
        chk("op", 32'(o_op), 32'(opb[5:0]));
        chk("busy_calc", 32'(o_busy), 1);
        chk("start_lat1", 32'(o_tx_start), 0);
        step();
        chk("start_lat2", 32'(o_tx_start), 0);
        step();
        chk("start_lat3", 32'(o_tx_start), 1);
        chk("tx_data", 32'(o_tx_data), 32'(alu_f(a, b, opb[5:0])));
        step();
        chk("start_one_cycle", 32'(o_tx_start), 0);
        chk("busy_wait_tx", 32'(o_busy), 1);
        chk("start_count", 32'(tx_start_cnt - s0), 1);
    endtask

    initial begin
        logic [7:0] ra, rb, ro, held;
        logic [7:0] ops [6];
        int d0;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};

        // reset state
        step(); step();
        i_reset = 1'b0;
        chk("rst_data_a", 32'(o_data_a), 0);
        chk("rst_data_b", 32'(o_data_b), 0);
        chk("rst_op", 32'(o_op), 0);
        chk("rst_tx_data", 32'(o_tx_data), 0);
        chk("rst_pulses", {29'd0, o_tx_start, o_drop_tick, o_timeout}, 0);
        chk("rst_busy", 32'(o_busy), 0);

        // basic add, then opcode upper bits ignored
        do_op(8'h05, 8'h03, 8'h20);
        chk("add_result", 32'(o_tx_data), 32'h08);
        finish_tx();
        do_op(8'h5A, 8'h11, 8'hE2);
        chk("op_masked", 32'(o_op), 32'h22);
        finish_tx();

        // byte during WAIT_TX is dropped
        do_op(8'h40, 8'h02, 8'h24);
        held = o_data_a;
        d0 = drop_cnt;
        send_byte(8'h77);
        chk("drop_pulse", 32'(o_drop_tick), 1);
        step();
        chk("drop_one_cycle", 32'(o_drop_tick), 0);
        chk("drop_count", 32'(drop_cnt - d0), 1);
        chk("drop_keeps_a", 32'(o_data_a), 32'(held));
        chk("drop_still_busy", 32'(o_busy), 1);
        finish_tx();

        // randomized operations
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = ops[$urandom_range(0, 5)] | {2'($urandom), 6'd0};
            do_op(ra, rb, ro);
            finish_tx();
        end

        // reset mid-collection loses the partial sequence
        send_byte(8'h11);
        chk("partial_a", 32'(o_data_a), 32'h11);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        chk("rst_mid_a", 32'(o_data_a), 0);
        chk("rst_mid_busy", 32'(o_busy), 0);
        do_op(8'hAA, 8'hBB, 8'h01);
        finish_tx();

        // idle after A
        d0 = timeout_cnt;
        send_byte(8'h3C);
        for (int i = 0; i < 16; i++) step();
`ifdef INTF_TIMEOUT_EN
        chk("timeout_pulse", 32'(o_timeout), 1);
        step();
        chk("timeout_count", 32'(timeout_cnt - d0), 1);
        send_byte(8'h4D);
        chk("after_timeout_a", 32'(o_data_a), 32'h4D);
        send_byte(8'h01);
        send_byte(8'h20);
        step(); step(); step();
        chk("after_timeout_tx", 32'(o_tx_data), 32'h4E);
        finish_tx();
`else
        chk("no_timeout", 32'(timeout_cnt - d0), 0);
        send_byte(8'h4D);
        chk("idle_then_b", 32'(o_data_b), 32'h4D);
        chk("idle_a_kept", 32'(o_data_a), 32'h3C);
        send_byte(8'h20);
        step(); step(); step();
        chk("idle_tx", 32'(o_tx_data), 32'h89);
        finish_tx();
`endif

        // rx and tx done in the same WAIT_TX cycle
        do_op(8'h21, 8'h12, 8'h26);
        held = o_data_a;
        d0 = drop_cnt;
        i_rx_data      = 8'h99;
        i_rx_done_tick = 1'b1;
        i_tx_done_tick = 1'b1;
        step();
        i_rx_done_tick = 1'b0;
        i_tx_done_tick = 1'b0;
        chk("both_idle", 32'(o_busy), 0);
        chk("both_drop", 32'(o_drop_tick), 1);
        chk("both_keeps_a", 32'(o_data_a), 32'(held));
        step();
        chk("both_drop_count", 32'(drop_cnt - d0), 1);
        send_byte(8'h5E);
        chk("both_next_a", 32'(o_data_a), 32'h5E);

        // tx_done outside WAIT_TX is ignored
        i_tx_done_tick = 1'b1;
        step();
        i_tx_done_tick = 1'b0;
        send_byte(8'h06);
        chk("txdone_ignored_b", 32'(o_data_b), 32'h06);
        send_byte(8'h20);
        step(); step();
        chk("txdone_ignored_tx", 32'(o_tx_data), 32'h64);
        step();
        finish_tx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
